// File: rtl/ula_multdiv_if.sv
// Start/busy/done handshake and operand/result bus of the multiply/divide unit.
// Master is the control unit; slave is ula_multdiv.
interface ula_multdiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, A, B,
        input  busy, done, div_zero, HI, LO
    );

    modport slave (
        input  start, op, A, B,
        output busy, done, div_zero, HI, LO
    );
endinterface

// File: rtl/ula_multdiv.sv
// Iterative MULT/MULTU/DIV/DIVU (one bit per cycle) plus MTHI/MTLO into HI/LO; ULA_MULTDIV_EARLY_TERM_EN skips CALC for zero operands.
// Latency WIDTH+2 edges to done (2 with early term); start is dropped, not queued, while busy.
module ula_multdiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    ula_multdiv_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opnd_q;
    logic [WIDTH-1:0]     a_raw_q;
    logic                 is_div_q;
    logic                 b_zero_q;
    logic                 neg_lo_q;
    logic                 neg_hi_q;
    logic                 done_q;
    logic                 div_zero_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                 accept;
    logic                 is_iter;
    logic                 is_signed;
    logic                 skip;
    logic                 neg_a;
    logic                 neg_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH-1:0]     rem_diff;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     hi_res;
    logic [WIDTH-1:0]     lo_res;

    // The done cycle still counts as busy so a new start cannot overlap the result write-back.
    assign accept    = (state_q == IDLE) && !done_q && bus.start;
    assign is_iter   = !bus.op[2];
    assign is_signed = !bus.op[0];

    assign neg_a = is_signed && bus.A[WIDTH-1];
    assign neg_b = is_signed && bus.B[WIDTH-1];
    assign mag_a = neg_a ? ({WIDTH{1'b0}} - bus.A) : bus.A;
    assign mag_b = neg_b ? ({WIDTH{1'b0}} - bus.B) : bus.B;

`ifdef ULA_MULTDIV_EARLY_TERM_EN
    assign skip = is_iter && ((bus.B == {WIDTH{1'b0}}) ||
                              (!bus.op[1] && (bus.A == {WIDTH{1'b0}})));
`else
    assign skip = 1'b0;
`endif

    // Shift-add: accumulate into the upper half, carry lands in the top bit after the shift.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Restoring divide; the remainder gets one guard bit so the shifted value never overflows.
    always_comb begin
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        rem_diff = rem_sh[WIDTH-1:0] - opnd_q;
        if (rem_sh >= {1'b0, opnd_q}) begin
            div_next = {rem_diff, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_fix = neg_lo_q ? ({(2*WIDTH){1'b0}} - acc_q) : acc_q;
        quot_fix = neg_lo_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_fix  = neg_hi_q ? ({WIDTH{1'b0}} - acc_q[2*WIDTH-1:WIDTH])
                            : acc_q[2*WIDTH-1:WIDTH];
        hi_res   = prod_fix[2*WIDTH-1:WIDTH];
        lo_res   = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            hi_res = b_zero_q ? a_raw_q : rem_fix;
            lo_res = b_zero_q ? {WIDTH{1'b1}} : quot_fix;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && is_iter) begin
                    state_d = skip ? FIX : CALC;
                end
            end
            CALC: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            a_raw_q    <= '0;
            is_div_q   <= 1'b0;
            b_zero_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && is_iter) begin
                        cnt_q    <= '0;
                        is_div_q <= bus.op[1];
                        a_raw_q  <= bus.A;
                        b_zero_q <= (bus.B == {WIDTH{1'b0}});
                        neg_lo_q <= neg_a ^ neg_b;
                        neg_hi_q <= neg_a;
                        if (bus.op[1]) begin
                            acc_q  <= {{WIDTH{1'b0}}, mag_a};
                            opnd_q <= mag_b;
                        end else begin
                            acc_q  <= skip ? {(2*WIDTH){1'b0}} : {{WIDTH{1'b0}}, mag_b};
                            opnd_q <= mag_a;
                        end
                    end else if (accept && (bus.op == 3'b100)) begin
                        hi_q <= bus.A;
                    end else if (accept && (bus.op == 3'b101)) begin
                        lo_q <= bus.A;
                    end
                end
                CALC: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    hi_q   <= hi_res;
                    lo_q   <= lo_res;
                    done_q <= 1'b1;
                    if (is_div_q) begin
                        div_zero_q <= b_zero_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state_q != IDLE) || done_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;

endmodule

// File: tb/tb_ula_multdiv.sv
// Scoreboard bench for ula_multdiv: directed vectors push expected HI/LO/div_zero and done cycle; a monitor checks each done pulse.
module tb_ula_multdiv;
    localparam int W = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_RSV   = 3'b110;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    ula_multdiv_if #(.WIDTH(W)) bus ();

    ula_multdiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef ULA_MULTDIV_EARLY_TERM_EN
        if (op[1] ? (b == '0) : ((a == '0) || (b == '0))) return 1;
`endif
        return W + 1;
    endfunction

    // Drives one start cycle; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit push, input logic [W-1:0] hi, input logic [W-1:0] lo,
                         input logic dz);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = 32'h5A5A_5A5A;
        bus.B     = 32'hA5A5_A5A5;
        if (push) begin
            e.hi  = hi;
            e.lo  = lo;
            e.dz  = dz;
            e.cyc = cyc + exp_lat(op, a, b);
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
        end
        if (bus.busy) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: busy still 1 after 200 cycles");
        end
    endtask

    task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz);
        issue(op, a, b, 1'b1, hi, lo, dz);
        @(negedge clk);
        chk("busy_after_start", 64'(bus.busy), 64'd1);
        wait_idle();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 with no pending operation (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("HI", 64'(bus.HI), 64'(e.hi));
                chk("LO", 64'(bus.LO), 64'(e.lo));
                chk("div_zero", 64'(bus.div_zero), 64'(e.dz));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("busy_in_done", 64'(bus.busy), 64'd1);
            end
        end
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.A     = '0;
        bus.B     = '0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #3;
        chk("rst_HI", 64'(bus.HI), 64'd0);
        chk("rst_LO", 64'(bus.LO), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_div_zero", 64'(bus.div_zero), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run(OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run(OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run(OP_DIVU,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        run(OP_MULTU, 32'd3,         32'd4,        32'd0,         32'd12,        1'b1);
        run(OP_DIVU,  32'd10,        32'd3,        32'd1,         32'd3,         1'b0);

        // Second start mid-operation with fresh operands must be dropped.
        issue(OP_MULTU, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42, 1'b0);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.A     = 32'd100;
        bus.B     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();

        issue(OP_MTHI, 32'h0000_ABCD, 32'd0, 1'b0, '0, '0, 1'b0);
        chk("mthi_HI", 64'(bus.HI), 64'h0000_ABCD);
        chk("mthi_LO_kept", 64'(bus.LO), 64'd42);
        chk("mthi_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        chk("mthi_done", 64'(bus.done), 64'd0);

        issue(OP_MTLO, 32'h0000_1357, 32'd0, 1'b0, '0, '0, 1'b0);
        chk("mtlo_LO", 64'(bus.LO), 64'h0000_1357);
        chk("mtlo_busy", 64'(bus.busy), 64'd0);

        issue(OP_RSV, 32'h1111_1111, 32'h2222_2222, 1'b0, '0, '0, 1'b0);
        chk("rsv_busy", 64'(bus.busy), 64'd0);
        chk("rsv_HI_kept", 64'(bus.HI), 64'h0000_ABCD);
        repeat (3) @(negedge clk);

        run(OP_MULT, 32'd0,         32'h55,        32'd0,         32'd0,         1'b0);
        run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
        run(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0);

        // Reset mid-operation: results cleared at once, no done afterwards.
        issue(OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, '0, '0, 1'b0);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_HI", 64'(bus.HI), 64'd0);
        chk("midrst_LO", 64'(bus.LO), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_busy", 64'(bus.busy), 64'd0);
        chk("post_rst_LO", 64'(bus.LO), 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
